// File: rtl/mux8_arb.sv
// Round-robin arbiter granting one of eight requesters a shared 16-bit 8:1 mux.
// Define MUX8_ARB_TIMEOUT_EN to compile in the MAX_HOLD hold watchdog.
module mux8_arb #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [0:0] {StIdle, StOwned} state_e;

    state_e     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] owner_q, owner_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] sel_q, sel_d;
    logic       busy_q, busy_d;

    logic [7:0]  arb_req;
    logic [15:0] arb_dbl;
    logic [7:0]  arb_rot;
    logic [2:0]  win_off;
    logic [2:0]  win_idx;
    logic        win_vld;

`ifdef MUX8_ARB_TIMEOUT_EN
    localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

    logic [7:0] hold_q, hold_d;
    logic       forced;
    logic       timeout_q, timeout_d;
`endif

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("mux8_arb: MAX_HOLD must be in 2..255");
    end

    // While owned, the owner never competes: covers both release and forced release.
    always_comb begin
        arb_req = req;
        if (state_q == StOwned) begin
            arb_req = req & ~(8'b1 << owner_q);
        end
    end

    // Rotate so that bit 0 is the requester at ptr, then take the lowest set bit.
    always_comb begin
        arb_dbl = {arb_req, arb_req};
        arb_rot = arb_dbl[ptr_q +: 8];
        win_off = 3'd0;
        win_vld = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            if (arb_rot[k]) begin
                win_off = 3'(k);
                win_vld = 1'b1;
            end
        end
        win_idx = ptr_q + win_off;
    end

    // State register, including the registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= 3'd0;
            owner_q <= 3'd0;
            gnt_q   <= 8'd0;
            sel_q   <= 3'd0;
            busy_q  <= 1'b0;
`ifdef MUX8_ARB_TIMEOUT_EN
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
`ifdef MUX8_ARB_TIMEOUT_EN
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
`ifdef MUX8_ARB_TIMEOUT_EN
        hold_d = hold_q;
        forced = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (win_vld) begin
                    state_d = StOwned;
                    owner_d = win_idx;
                    ptr_d   = win_idx + 3'd1;
`ifdef MUX8_ARB_TIMEOUT_EN
                    hold_d = 8'd0;
`endif
                end
            end
            StOwned: begin
                if (req[owner_q]) begin
`ifdef MUX8_ARB_TIMEOUT_EN
                    if (hold_q == HoldLast) begin
                        // With nobody else pending the owner is regranted; ptr already
                        // points past it.
                        forced = 1'b1;
                        hold_d = 8'd0;
                        if (win_vld) begin
                            owner_d = win_idx;
                            ptr_d   = win_idx + 3'd1;
                        end
                    end else begin
                        hold_d = hold_q + 8'd1;
                    end
`endif
                end else if (win_vld) begin
                    owner_d = win_idx;
                    ptr_d   = win_idx + 3'd1;
`ifdef MUX8_ARB_TIMEOUT_EN
                    hold_d = 8'd0;
`endif
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs, decoded from the next state.
    always_comb begin
        gnt_d  = 8'd0;
        sel_d  = 3'd0;
        busy_d = 1'b0;
`ifdef MUX8_ARB_TIMEOUT_EN
        timeout_d = forced;
`endif
        if (state_d == StOwned) begin
            gnt_d  = 8'b1 << owner_d;
            sel_d  = owner_d;
            busy_d = 1'b1;
        end
    end

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign busy = busy_q;
`ifdef MUX8_ARB_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_busy_match: assert property (@(posedge clk) disable iff (rst) busy == (gnt != 8'd0));
    a_sel_match:  assert property (@(posedge clk) disable iff (rst)
                                   gnt == (busy ? (8'b1 << sel) : 8'd0));
`ifndef MUX8_ARB_TIMEOUT_EN
    a_hold_grant: assert property (@(posedge clk) disable iff (rst)
                                   busy && req[sel] |=> $stable(gnt));
`endif

endmodule

// File: tb/tb_mux8_arb.sv
// Self-checking bench for mux8_arb: reference model feeds a scoreboard queue,
// plus directed checks for the reset, release, fairness, handover and wrap cases.
module tb_mux8_arb;

    localparam int unsigned TbHold = 4;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       timeout;

    mux8_arb #(.MAX_HOLD(TbHold)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .sel     (sel),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;

    // Scoreboard entry: {gnt, sel, busy, timeout}
    logic [12:0] sb_q[$];

    // Reference model state
    bit         m_owned;
    logic [2:0] m_ptr;
    logic [2:0] m_owner;
    int         m_hold;
    bit         m_to;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [7:0] r, input logic [2:0] p);
        for (int k = 0; k < 8; k++) begin
            int idx;
            idx = (int'(p) + k) % 8;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic m_grant(input int w);
        m_owned = 1'b1;
        m_owner = 3'(w);
        m_ptr   = 3'((w + 1) % 8);
        m_hold  = 0;
    endtask

    task automatic model(input logic [7:0] r, input logic rs);
        int         w;
        logic [7:0] others;
        m_to   = 1'b0;
        others = r & ~(8'd1 << m_owner);
        if (rs) begin
            m_owned = 1'b0;
            m_ptr   = 3'd0;
            m_owner = 3'd0;
            m_hold  = 0;
        end else if (!m_owned) begin
            w = pick(r, m_ptr);
            if (w >= 0) m_grant(w);
        end else if (r[m_owner]) begin
`ifdef MUX8_ARB_TIMEOUT_EN
            if (m_hold == int'(TbHold) - 1) begin
                m_to = 1'b1;
                w = pick(others, m_ptr);
                if (w < 0) w = int'(m_owner);
                m_grant(w);
            end else begin
                m_hold++;
            end
`endif
        end else begin
            w = pick(others, m_ptr);
            if (w >= 0) m_grant(w);
            else m_owned = 1'b0;
        end
    endtask

    // Drive one cycle, push the model's prediction, compare after the edge.
    task automatic step(input logic [7:0] r, input logic rs);
        logic [12:0] exp_v;
        @(negedge clk);
        req = r;
        rst = rs;
        model(r, rs);
        exp_v = {(m_owned ? (8'd1 << m_owner) : 8'd0), (m_owned ? m_owner : 3'd0),
                 m_owned, m_to};
        sb_q.push_back(exp_v);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            check("sb", 32'({gnt, sel, busy, timeout}), 32'(sb_q.pop_front()));
        end
    endtask

    initial begin
        logic [7:0] r;
        logic [2:0] cur;
        req = 8'd0;
        rst = 1'b1;
        m_owned = 1'b0; m_ptr = 3'd0; m_owner = 3'd0; m_hold = 0; m_to = 1'b0;

        // Reset state
        step(8'h00, 1'b1);
        step(8'h00, 1'b1);
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        // Reset mid-grant
        step(8'h04, 1'b0);
        step(8'h04, 1'b0);
        step(8'h04, 1'b0);
        check("mid_gnt", 32'(gnt), 32'h04);
        step(8'h04, 1'b1);
        check("mid_rst_gnt", 32'(gnt), 32'h0);
        check("mid_rst_sel", 32'(sel), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        step(8'h04, 1'b0);
        check("mid_regrant", 32'(gnt), 32'h04);
        step(8'h00, 1'b0);
        check("mid_release", 32'(gnt), 32'h0);

        // Single request, then release
        for (int i = 1; i <= 5; i++) begin
            step(8'h10, 1'b0);
            check("single_gnt", 32'(gnt), 32'h10);
            check("single_sel", 32'(sel), 32'd4);
        end
        step(8'h00, 1'b0);
        check("single_idle_gnt", 32'(gnt), 32'h0);
        check("single_idle_busy", 32'(busy), 32'h0);

        // Round-robin fairness from ptr=0
        step(8'h00, 1'b1);
        step(8'hFF, 1'b0);
        check("rr_first", 32'(gnt), 32'h01);
        cur = 3'd0;
        for (int i = 1; i <= 8; i++) begin
            step(8'hFF & ~(8'd1 << cur), 1'b0);
            check("rr_gnt", 32'(gnt), 32'(8'd1 << (i % 8)));
            cur = 3'(i % 8);
        end

        // Zero-bubble handover from requester 7 to 0
        step(8'h80, 1'b0);
        step(8'h81, 1'b0);
        check("zb_owner7", 32'(gnt), 32'h80);
        step(8'h01, 1'b0);
        check("zb_gnt", 32'(gnt), 32'h01);
        check("zb_sel", 32'(sel), 32'd0);
        check("zb_busy", 32'(busy), 32'd1);

        // Pointer wrap: after 6 is granted and released, 0 beats 6
        step(8'h40, 1'b0);
        check("wrap_g6", 32'(gnt), 32'h40);
        step(8'h00, 1'b0);
        step(8'h41, 1'b0);
        check("wrap_gnt", 32'(gnt), 32'h01);

        // A non-owner pulse while owned is not remembered
        step(8'h03, 1'b0);
        step(8'h01, 1'b0);
        step(8'h00, 1'b0);
        check("pulse_lost", 32'(gnt), 32'h0);

`ifdef MUX8_ARB_TIMEOUT_EN
        // Watchdog with another requester pending
        step(8'h00, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            step(8'h03, 1'b0);
            check("wd_hold", 32'(gnt), 32'h01);
            check("wd_hold_to", 32'(timeout), 32'd0);
        end
        step(8'h03, 1'b0);
        check("wd_switch", 32'(gnt), 32'h02);
        check("wd_switch_to", 32'(timeout), 32'd1);
        // Lone requester is regranted with a pulse every TbHold cycles
        step(8'h00, 1'b1);
        for (int k = 1; k <= 13; k++) begin
            step(8'h01, 1'b0);
            check("wd_regrant", 32'(gnt), 32'h01);
            check("wd_pulse", 32'(timeout), 32'((k >= 5) && ((k - 1) % 4 == 0)));
        end
`endif

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            r = 8'($urandom) & 8'($urandom);
            step(r, $urandom_range(0, 49) == 0);
        end
        step(8'h00, 1'b0);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
